sys_ctrl: RTL

Command sequencer between the UART RX byte stream and the register file, ALU and TX FIFO of the multi-clock system. It consumes validated frames (RX_P_DATA/RX_D_VLD from the UART RX deserializer) and decodes 1-byte command opcodes plus operand bytes. It drives register-file write/read strobes, ALU enable/function and the ALU clock-gate enable. Response bytes (read data, ALU result LSB then MSB) are pushed into the TX async FIFO.

---
 rtl/sys_ctrl_pkg.sv | 27 ++
 rtl/sys_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the command sequencer: opcodes, operand register slots, FSM encoding.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_ADDR   = 4'd1,
        WR_DATA   = 4'd2,
        RD_ADDR   = 4'd3,
        RD_WAIT   = 4'd4,
        OP_A      = 4'd5,
        OP_B      = 4'd6,
        ALU_FUN_S = 4'd7,
        ALU_WAIT  = 4'd8,
        SEND_RD   = 4'd9,
        SEND_LO   = 4'd10,
        SEND_HI   = 4'd11
    } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes RX bytes into regfile/ALU strobes and queues responses to TX FIFO.
// Strobes are combinational in the RX_D_VLD cycle; response sends stall (no loss) while FIFO_FULL.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FUN_WIDTH     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     OUT_Valid,
    input  logic                     FIFO_FULL,
    output logic                     ALU_EN,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     CLK_EN,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD
);

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      rd_q, rd_d;
    logic [ALU_OUT_WIDTH-1:0]   res_q, res_d;
    logic [FUN_WIDTH-1:0]       fun_q, fun_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            fun_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            fun_q   <= fun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        res_d     = res_q;
        fun_d     = fun_q;
        ALU_EN    = 1'b0;
        ALU_FUN   = fun_q;
        CLK_EN    = 1'b0;
        Address   = addr_q;
        WrEn      = 1'b0;
        RdEn      = 1'b0;
        WrData    = '0;
        TX_P_DATA = '0;
        TX_D_VLD  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_WIDTH'(CMD_WR))           state_d = WR_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))      state_d = RD_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = OP_A;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ALU_FUN_S;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    WrEn    = 1'b1;
                    WrData  = RX_P_DATA;
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                // Address bypasses the register so the read issues in the byte's own cycle.
                if (RX_D_VLD) begin
                    RdEn    = 1'b1;
                    Address = RX_P_DATA[ADDR_WIDTH-1:0];
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RdData_Valid) begin
                    rd_d    = RdData;
                    state_d = SEND_RD;
                end
            end
            OP_A: begin
                if (RX_D_VLD) begin
                    WrEn    = 1'b1;
                    Address = ADDR_WIDTH'(OPA_ADDR);
                    WrData  = RX_P_DATA;
                    state_d = OP_B;
                end
            end
            OP_B: begin
                if (RX_D_VLD) begin
                    WrEn    = 1'b1;
                    Address = ADDR_WIDTH'(OPB_ADDR);
                    WrData  = RX_P_DATA;
                    state_d = ALU_FUN_S;
                end
            end
            ALU_FUN_S: begin
                CLK_EN = 1'b1;
                if (RX_D_VLD) begin
                    ALU_EN  = 1'b1;
                    ALU_FUN = RX_P_DATA[FUN_WIDTH-1:0];
                    fun_d   = RX_P_DATA[FUN_WIDTH-1:0];
                    state_d = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                CLK_EN = 1'b1;
                if (OUT_Valid) begin
                    res_d   = ALU_OUT;
                    state_d = SEND_LO;
                end
            end
            SEND_RD: begin
                if (!FIFO_FULL) begin
                    TX_D_VLD  = 1'b1;
                    TX_P_DATA = rd_q;
                    state_d   = IDLE;
                end
            end
            SEND_LO: begin
                if (!FIFO_FULL) begin
                    TX_D_VLD  = 1'b1;
                    TX_P_DATA = res_q[DATA_WIDTH-1:0];
                    state_d   = SEND_HI;
                end
            end
            SEND_HI: begin
                if (!FIFO_FULL) begin
                    TX_D_VLD  = 1'b1;
                    TX_P_DATA = res_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
